isqrt_iter_responder: RTL
=========================

# isqrt_iter_responder

Iterative integer square-root responder for the isqrt interface used by the formula FSMs. It accepts a request `x_vld`/`x` and returns `y = floor(sqrt(x))` on `y_vld`/`y`. It uses one restoring digit-by-digit step per clock, so it is much smaller than the pipelined isqrt. A one-entry pending register absorbs the request an initiator issues in the same cycle it sees `y_vld`, plus one more request that arrives while busy.

## Interface
- `XW`, 32, operand width; must be even. `YW = XW/2` is derived, not overridable.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `x_vld`  in  1  request strobe; one request per high cycle.
- `x`  in  XW  radicand; sampled only when `x_vld` is high.
- `y_vld`  out  1  one-cycle result strobe; registered.
- `y`  out  YW  root; holds the last result until the next completion.
- `busy`  out  1  high while the core is in state CALC.
- `err`  out  1  sticky request-dropped flag; cleared only by `rst`.

## Operation
- States (`isqrt_pkg::state_t`): IDLE, CALC.
- Core registers:
  - `rem`, YW+2 bits.
  - `root`, YW bits.
  - `xs`, XW bits: radicand shifted left 2 per step.
  - `cnt`, 0..YW-1.
  - `pend_vld` and `pend_x`: the one-entry pending register.
- Load (from `x` or `pend_x`): `xs` = source, `rem` = 0, `root` = 0, `cnt` = 0, state = CALC.
- Step, in CALC, per edge:
  - `r2 = {rem, xs[XW-1:XW-2]}`, truncated to YW+2 bits; `t = {root, 2'b01}`.
  - If `r2 >= t`: `rem = r2 - t`, `root = {root, 1}`. Otherwise `rem = r2`, `root = {root, 0}`.
  - `xs <<= 2`, `cnt++`.
- Completion, at the step edge with `cnt == YW-1`:
  - `y` gets the final root; `y_vld` = 1 for the next cycle.
  - If `pend_vld`: load from `pend_x`, clear `pend_vld`, stay in CALC. Otherwise go to IDLE.
- Accept rules, evaluated on every edge:
  - IDLE and `x_vld` (pending is always empty in IDLE): load from `x`.
  - CALC and `x_vld`:
    - `pend_vld == 0`: store into pending.
    - `pend_vld == 1` and this is a completion edge: pending moves into the core and `x` goes into pending.
    - Otherwise: drop `x` and set `err`.
- Reset values: state IDLE, `y_vld` 0, `y` 0, `busy` 0, `err` 0, `pend_vld` 0. Core datapath registers are don't-care.
- Reset mid-operation abandons the core and pending contents. No `y_vld` follows.
- Arithmetic is unsigned. `x = 0` gives `y = 0`. Max `x = 2^XW-1` gives `y = 2^YW-1`.

## Timing
- Latency is YW+1 clocks:
  - `x_vld` high in cycle 0 → load at edge 0 → YW step edges → `y_vld` high in cycle YW+1.
  - For XW=32 this is `y_vld` in cycle 17.
- `y_vld` is exactly one cycle wide per request. A queued request completes exactly YW clocks after the previous result.
- The unit is IDLE again in the `y_vld` cycle when nothing is pending. A new `x_vld` in that cycle is loaded immediately.
- Chained initiator traffic (`x_vld` in the `y_vld` cycle) therefore sustains one result per YW+1 clocks with no drops.
- `busy` is the registered state: it is high in cycles 1..YW for an isolated request.

## Structure
- `isqrt_pkg` holds `state_t` and a helper function `isqrt_ref` (behavioural floor-sqrt) for benches.
- Sub-module `isqrt_step`: purely combinational single iteration, `(rem, root, top2) -> (rem', root')`, instantiated once.
- The top level holds the FSM, counter, pending register and output registers.

## Test plan
1. `x = 16` in cycle 0 → `y_vld` only in cycle 17, `y = 4`, `busy` high in cycles 1–16, `err = 0`.
2. `x = 0`, then `x = 0xFFFF_FFFF`, then `x = 15` (each issued while idle) → `y` = 0, 0xFFFF, 3.
3. Chained formula traffic: `x = 16`; in the `y_vld` cycle send `x = 5 + 4`; then `x = 6 + 3` → `y` = 4, 3, 3 at cycles 17, 34, 51.
4. `x` = 100, 81, 64 on three consecutive cycles → results 10, 9 at cycles 17 and 33; 64 is dropped and `err` = 1 from cycle 3 onward.
5. `x = 100`, then `x = 81` at cycle 5, then `x = 49` in cycle 16 → 10 at cycle 17, 9 at cycle 33, 7 at cycle 49, `err = 0`.
6. `x = 1000` and `x = 400` (pending), then `rst` at cycle 8 → no `y_vld` ever appears, all outputs 0. A following `x = 1000` gives `y = 31` after 17 cycles.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared types for the iterative isqrt responder.
// Holds the FSM state type and a behavioural floor-sqrt reference.
package isqrt_pkg;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    // Floor square root of a 32-bit value, bit by bit from the MSB.
    function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] c;
        logic [63:0] sq;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            c  = r | (32'd1 << b);
            sq = {32'd0, c} * {32'd0, c};
            if (sq <= {32'd0, v}) r = c;
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit step of the integer square root.
// Purely combinational: (rem, root, top2) -> (rem', root').
module isqrt_step #(
    parameter int YW = 16
) (
    input  logic [YW+1:0] rem,
    input  logic [YW-1:0] root,
    input  logic [1:0]    top2,
    output logic [YW+1:0] rem_nxt,
    output logic [YW-1:0] root_nxt
);

    logic [YW+1:0] r2;
    logic [YW+1:0] t;
    logic          ge;

    // The dropped upper remainder bits are always zero before they matter.
    assign r2 = (YW+2)'({rem, top2});
    assign t  = {root, 2'b01};
    assign ge = (r2 >= t);

    assign rem_nxt  = ge ? (r2 - t) : r2;
    assign root_nxt = {root[YW-2:0], ge};

endmodule

// File: rtl/isqrt_iter_responder.sv
// Iterative integer square-root responder, one digit per clock.
// Includes a one-entry pending slot for back-to-back requests.
module isqrt_iter_responder
    import isqrt_pkg::*;
#(
    parameter int XW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_vld,
    input  logic [XW-1:0]     x,
    output logic              y_vld,
    output logic [XW/2-1:0]   y,
    output logic              busy,
    output logic              err
);

    localparam int YW = XW / 2;
    localparam int CW = (YW > 1) ? $clog2(YW) : 1;
    localparam logic [CW-1:0] LAST = CW'(YW - 1);

    state_t          state, state_nxt;
    logic [YW+1:0]   rem, rem_nxt;
    logic [YW-1:0]   root, root_nxt;
    logic [XW-1:0]   xs, xs_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            pend_vld, pend_vld_nxt;
    logic [XW-1:0]   pend_x, pend_x_nxt;
    logic            y_vld_nxt;
    logic [YW-1:0]   y_nxt;
    logic            err_nxt;

    logic [YW+1:0]   step_rem;
    logic [YW-1:0]   step_root;
    logic            done;
    logic            ld;
    logic [XW-1:0]   ld_src;

    isqrt_step #(
        .YW(YW)
    ) u_step (
        .rem      (rem),
        .root     (root),
        .top2     (xs[XW-1:XW-2]),
        .rem_nxt  (step_rem),
        .root_nxt (step_root)
    );

    assign done = (state == CALC) && (cnt == LAST);
    assign busy = (state == CALC);

    always_comb begin
        state_nxt    = state;
        rem_nxt      = rem;
        root_nxt     = root;
        xs_nxt       = xs;
        cnt_nxt      = cnt;
        pend_vld_nxt = pend_vld;
        pend_x_nxt   = pend_x;
        y_nxt        = y;
        y_vld_nxt    = 1'b0;
        err_nxt      = err;
        ld           = 1'b0;
        ld_src       = x;

        unique case (state)
            IDLE: begin
                if (x_vld) begin
                    ld     = 1'b1;
                    ld_src = x;
                end
            end
            CALC: begin
                rem_nxt  = step_rem;
                root_nxt = step_root;
                xs_nxt   = {xs[XW-3:0], 2'b00};
                cnt_nxt  = cnt + 1'b1;
                if (done) begin
                    y_nxt     = step_root;
                    y_vld_nxt = 1'b1;
                    if (pend_vld) begin
                        ld           = 1'b1;
                        ld_src       = pend_x;
                        pend_vld_nxt = x_vld;
                        pend_x_nxt   = x_vld ? x : pend_x;
                    end else if (x_vld) begin
                        // Empty slot at completion: start the new one at once.
                        ld     = 1'b1;
                        ld_src = x;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (x_vld) begin
                    if (!pend_vld) begin
                        pend_vld_nxt = 1'b1;
                        pend_x_nxt   = x;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (ld) begin
            xs_nxt    = ld_src;
            rem_nxt   = '0;
            root_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_vld <= 1'b0;
            y_vld    <= 1'b0;
            y        <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_vld <= pend_vld_nxt;
            y_vld    <= y_vld_nxt;
            y        <= y_nxt;
            err      <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        rem    <= rem_nxt;
        root   <= root_nxt;
        xs     <= xs_nxt;
        cnt    <= cnt_nxt;
        pend_x <= pend_x_nxt;
    end

endmodule
